// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: I-cache, D-cache and memory-port signals of the memory arbiter
interface mem_arbiter_if #(parameter int ADDR = 32, parameter int DATA = 32);
  logic            ic_req, ic_gnt, ic_rvalid, ic_flush;
  logic [ADDR-1:0] ic_addr;
  logic [DATA-1:0] ic_rdata;
  logic            dc_req, dc_we, dc_wnext, dc_gnt, dc_rvalid;
  logic [ADDR-1:0] dc_addr;
  logic [DATA-1:0] dc_wdata, dc_rdata;
  logic            mem_req, mem_we, mem_ack, mem_rvalid, mem_wready;
  logic [ADDR-1:0] mem_addr;
  logic [DATA-1:0] mem_wdata, mem_rdata;
  modport master (
    input  ic_req, ic_addr, ic_flush, dc_req, dc_we, dc_addr, dc_wdata,
           mem_ack, mem_rvalid, mem_rdata, mem_wready,
    output ic_gnt, ic_rvalid, ic_rdata, dc_wnext, dc_gnt, dc_rvalid, dc_rdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    output ic_req, ic_addr, ic_flush, dc_req, dc_we, dc_addr, dc_wdata,
           mem_ack, mem_rvalid, mem_rdata, mem_wready,
    input  ic_gnt, ic_rvalid, ic_rdata, dc_wnext, dc_gnt, dc_rvalid, dc_rdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin burst arbiter sharing one memory port between I-cache and D-cache
module mem_arbiter #(
  parameter int ADDR  = 32,
  parameter int DATA  = 32,
  parameter int BEATS = 4
) (
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.master bus
);
  localparam int CNT = $clog2(BEATS);
  typedef enum logic [2:0] {IDLE, IC_CMD, IC_DATA, DC_CMD, DC_DATA} state_t;
  state_t         state_q, state_d;
  logic [CNT-1:0] cnt_q, cnt_d;
  logic           last_dc_q, last_dc_d, drop_q, drop_d, we_q, we_d;
  logic           beat, last;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_dc_d = last_dc_q;
    drop_d    = drop_q;
    we_d      = we_q;
    beat = (state_q == IC_DATA) ? bus.mem_rvalid :
           (state_q == DC_DATA) ? (we_q ? bus.mem_wready : bus.mem_rvalid) : 1'b0;
    last = beat && (cnt_q == CNT'(BEATS - 1));
    case (state_q)
      IDLE:
        if (bus.ic_req && !bus.ic_flush && (!bus.dc_req || last_dc_q)) begin
          state_d   = IC_CMD;
          last_dc_d = 1'b0;
        end else if (bus.dc_req) begin
          state_d   = DC_CMD;
          last_dc_d = 1'b1;
        end
      IC_CMD:
        if (bus.mem_ack) begin
          state_d = IC_DATA;
          cnt_d   = '0;
          drop_d  = bus.ic_flush;
        end else if (bus.ic_flush) state_d = IDLE;
      IC_DATA: drop_d = drop_q | bus.ic_flush;
      DC_CMD:
        if (bus.mem_ack) begin
          state_d = DC_DATA;
          cnt_d   = '0;
          we_d    = bus.dc_we;
        end
      default: ;
    endcase
    if (beat) cnt_d = cnt_q + 1'b1;
    if (last) begin
      state_d = IDLE;
      cnt_d   = '0;
      drop_d  = 1'b0;
    end
  end
  // last_dc resets high so the I-cache wins the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_dc_q <= 1'b1;
      drop_q    <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_dc_q <= last_dc_d;
      drop_q    <= drop_d;
      we_q      <= we_d;
    end
  end
  assign bus.mem_req   = (state_q == IC_CMD) || (state_q == DC_CMD);
  assign bus.mem_we    = (state_q == DC_CMD) && bus.dc_we;
  assign bus.mem_addr  = (state_q == IC_CMD) ? bus.ic_addr : (state_q == DC_CMD) ? bus.dc_addr : '0;
  assign bus.mem_wdata = (state_q == DC_DATA && we_q) ? bus.dc_wdata : '0;
  assign bus.ic_gnt    = (state_q == IC_CMD) && bus.mem_ack;
  assign bus.dc_gnt    = (state_q == DC_CMD) && bus.mem_ack;
  assign bus.ic_rvalid = (state_q == IC_DATA) && bus.mem_rvalid && !drop_q && !bus.ic_flush;
  assign bus.ic_rdata  = (state_q == IC_DATA) ? bus.mem_rdata : '0;
  assign bus.dc_rvalid = (state_q == DC_DATA) && !we_q && bus.mem_rvalid;
  assign bus.dc_rdata  = (state_q == DC_DATA && !we_q) ? bus.mem_rdata : '0;
  assign bus.dc_wnext  = (state_q == DC_DATA) && we_q && bus.mem_wready;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a queue scoreboard checked by a negedge monitor
module tb_mem_arbiter;
  localparam int K_ICG = 0, K_ICR = 1, K_DCG = 2, K_DCR = 3, K_DCW = 4;
  typedef struct {int k; logic [31:0] d;} exp_t;
  logic clk, reset;
  int checks = 0, fails = 0;
  exp_t q[$];
  string kn[5] = '{"ic_gnt", "ic_rvalid", "dc_gnt", "dc_rvalid", "dc_wnext"};
  mem_arbiter_if ifc ();
  mem_arbiter dut (.clk(clk), .reset(reset), .bus(ifc));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", n, got, exp);
    end
  endtask
  task automatic idle_chk(input string n);
    chk({n, "_ctl"}, {ifc.mem_req, ifc.mem_we, ifc.ic_gnt, ifc.dc_gnt, ifc.ic_rvalid,
                      ifc.dc_rvalid, ifc.dc_wnext}, 0);
    chk({n, "_data"}, ifc.mem_addr | ifc.mem_wdata | ifc.ic_rdata | ifc.dc_rdata, 0);
  endtask
  // caller has just raised the request from IDLE; command must appear exactly one cycle later
  task automatic ack_cmd(input int k, input logic [31:0] a, input logic we, input int dly);
    q.push_back('{k: k, d: a});
    chk("req_latency0", ifc.mem_req, 0);
    tick();
    chk("req_latency1", ifc.mem_req, 1);
    repeat (dly) tick();
    chk("cmd_we", ifc.mem_we, we);
    ifc.mem_ack = 1'b1;
    tick();
    ifc.mem_ack = 1'b0;
  endtask
  task automatic beat_rd(input logic [31:0] d, input int k);
    if (k >= 0) q.push_back('{k: k, d: d});
    ifc.mem_rvalid = 1'b1;
    ifc.mem_rdata  = d;
    tick();
    ifc.mem_rvalid = 1'b0;
  endtask
  task automatic beat_wr(input logic [31:0] d);
    q.push_back('{k: K_DCW, d: d});
    ifc.dc_wdata   = d;
    ifc.mem_wready = 1'b1;
    tick();
    ifc.mem_wready = 1'b0;
  endtask
  always @(negedge clk) begin
    int k;
    logic [31:0] d;
    exp_t e;
    k = -1;
    d = '0;
    if (!reset) begin
      if (ifc.ic_gnt) begin k = K_ICG; d = ifc.mem_addr; end
      else if (ifc.ic_rvalid) begin k = K_ICR; d = ifc.ic_rdata; end
      else if (ifc.dc_gnt) begin k = K_DCG; d = ifc.mem_addr; end
      else if (ifc.dc_rvalid) begin k = K_DCR; d = ifc.dc_rdata; end
      else if (ifc.dc_wnext) begin k = K_DCW; d = ifc.mem_wdata; end
      if (k >= 0) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected %s data=%h, required no output", kn[k], d);
        end else begin
          e = q.pop_front();
          if (e.k != k || e.d !== d) begin
            fails++;
            $display("FAIL scoreboard: got %s/%h required %s/%h", kn[k], d, kn[e.k], e.d);
          end
        end
      end
    end
  end
  initial begin
    {ifc.ic_req, ifc.ic_flush, ifc.dc_req, ifc.dc_we, ifc.mem_ack, ifc.mem_rvalid, ifc.mem_wready} = '0;
    ifc.ic_addr = '0; ifc.dc_addr = '0; ifc.dc_wdata = '0;
    ifc.mem_rdata = 32'hDEADBEEF;
    reset = 1'b1;
    repeat (3) tick();
    idle_chk("reset");
    reset = 1'b0;
    tick();
    idle_chk("post_reset");
    // single I-cache burst, ack two cycles after mem_req, beats with gaps
    ifc.ic_req = 1'b1; ifc.ic_addr = 32'h100;
    ack_cmd(K_ICG, 32'h100, 1'b0, 2);
    ifc.ic_req = 1'b0;
    beat_rd(32'hD0, K_ICR); tick();
    beat_rd(32'hD1, K_ICR); tick(); tick();
    beat_rd(32'hD2, K_ICR);
    beat_rd(32'hD3, K_ICR);
    idle_chk("t2_end");
    // tie after reset: IC first, then DC write, then next tie goes to IC again
    reset = 1'b1; tick(); reset = 1'b0;
    ifc.ic_req = 1'b1; ifc.ic_addr = 32'h200;
    ifc.dc_req = 1'b1; ifc.dc_we = 1'b1; ifc.dc_addr = 32'h300;
    ack_cmd(K_ICG, 32'h200, 1'b0, 1);
    ifc.ic_req = 1'b0;
    for (int i = 0; i < 4; i++) beat_rd(32'hB0 + i, K_ICR);
    ack_cmd(K_DCG, 32'h300, 1'b1, 0);
    ifc.dc_req = 1'b0;
    for (int i = 0; i < 4; i++) beat_wr(32'hA0 + i);
    idle_chk("t3_wr_end");
    ifc.ic_req = 1'b1; ifc.ic_addr = 32'h400;
    ifc.dc_req = 1'b1; ifc.dc_we = 1'b0; ifc.dc_addr = 32'h480;
    ack_cmd(K_ICG, 32'h400, 1'b0, 0);
    ifc.ic_req = 1'b0;
    for (int i = 0; i < 4; i++) beat_rd(32'hC0 + i, K_ICR);
    ack_cmd(K_DCG, 32'h480, 1'b0, 1);
    ifc.dc_req = 1'b0;
    for (int i = 0; i < 4; i++) beat_rd(32'hC8 + i, K_DCR);
    // flush in IC_DATA after beat 1 with a D-cache read pending
    ifc.ic_req = 1'b1; ifc.ic_addr = 32'h500;
    ifc.dc_req = 1'b1; ifc.dc_we = 1'b0; ifc.dc_addr = 32'h600;
    ack_cmd(K_ICG, 32'h500, 1'b0, 0);
    ifc.ic_req = 1'b0;
    beat_rd(32'hE0, K_ICR);
    beat_rd(32'hE1, K_ICR);
    ifc.ic_flush = 1'b1; tick(); ifc.ic_flush = 1'b0;
    beat_rd(32'hE2, -1);
    beat_rd(32'hE3, -1);
    ack_cmd(K_DCG, 32'h600, 1'b0, 0);
    ifc.dc_req = 1'b0;
    for (int i = 0; i < 4; i++) beat_rd(32'hE8 + i, K_DCR);
    // flush in IC_CMD without ack withdraws the command
    ifc.ic_req = 1'b1; ifc.ic_addr = 32'h700;
    tick();
    chk("t5_cmd", ifc.mem_req, 1);
    ifc.ic_flush = 1'b1; ifc.ic_req = 1'b0;
    chk("t5_no_gnt", ifc.ic_gnt, 0);
    tick();
    ifc.ic_flush = 1'b0;
    chk("t5_withdrawn", ifc.mem_req, 0);
    tick();
    idle_chk("t5_idle");
    // flush coinciding with ack: gnt still pulses, whole burst dropped
    ifc.ic_req = 1'b1; ifc.ic_addr = 32'h800;
    q.push_back('{k: K_ICG, d: 32'h800});
    tick();
    ifc.ic_flush = 1'b1; ifc.mem_ack = 1'b1;
    tick();
    ifc.ic_flush = 1'b0; ifc.mem_ack = 1'b0; ifc.ic_req = 1'b0;
    for (int i = 0; i < 4; i++) beat_rd(32'hF0 + i, -1);
    idle_chk("t5b_idle");
    ifc.ic_req = 1'b1; ifc.ic_addr = 32'h880;
    ack_cmd(K_ICG, 32'h880, 1'b0, 0);
    ifc.ic_req = 1'b0;
    for (int i = 0; i < 4; i++) beat_rd(32'h90 + i, K_ICR);
    // reset in DC_DATA after two beats, then a stray beat
    ifc.dc_req = 1'b1; ifc.dc_we = 1'b0; ifc.dc_addr = 32'h900;
    ack_cmd(K_DCG, 32'h900, 1'b0, 0);
    ifc.dc_req = 1'b0;
    beat_rd(32'h60, K_DCR);
    beat_rd(32'h61, K_DCR);
    reset = 1'b1;
    tick();
    idle_chk("t6_reset");
    reset = 1'b0;
    ifc.mem_rvalid = 1'b1; ifc.mem_rdata = 32'h62;
    chk("t6_stray", ifc.dc_rvalid, 0);
    tick();
    ifc.mem_rvalid = 1'b0;
    idle_chk("t6_idle");
    tick(); tick();
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
